mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous RAM between the instruction-fetch port and the load/store port of the 5-stage pipeline.
- Enables a unified instruction/data memory.
- Grants one requester per cycle, steers address, data and write-enable to the RAM, and routes the 1-cycle-latency read data back with a valid strobe.
- The losing requester sees a low grant and must stall its stage.

Parameters:
- ADDR_W, 8, RAM word-address width.
- DATA_W, 32, data word width.
- STARVE_MAX, 4, consecutive lost conflict cycles after which fetch is forced through (ARB_FAIR_EN only).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-low reset.
- if_req  in  1  fetch read request.
- if_addr  in  ADDR_W  fetch word address.
- if_gnt  out  1  fetch granted this cycle (combinational).
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DATA_W  fetch read data, held between reads.
- d_req  in  1  data-port request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data port granted this cycle (combinational).
- d_rvalid  out  1  load data valid.
- d_rdata  out  DATA_W  load data, held between loads.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_wren  out  1  RAM write enable.
- ram_dout  in  DATA_W  RAM read data, valid the cycle after the address edge.
- conflict_cnt  out  16  saturating count of cycles where both ports requested.

Behaviour:
- Arbitration is combinational, one grant per cycle.
  - Default (strict priority): d_gnt = d_req; if_gnt = if_req & ~d_gnt.
  - No request: both grants 0, ram_wren 0, ram_addr = if_addr.
- RAM steering:
  - ram_addr = d_gnt ? d_addr : if_addr.
  - ram_din = d_wdata, always.
  - ram_wren = d_gnt & d_we.
- Read latency is 1 cycle.
  - At the rising edge: if_rvalid <= if_gnt; d_rvalid <= d_gnt & ~d_we.
  - rvalid is a single-cycle pulse per granted read.
  - Back-to-back grants give back-to-back pulses, so full throughput is one access per cycle.
- Read data:
  - x_rdata = x_rvalid ? ram_dout : x_hold.
  - x_hold captures ram_dout on every edge where x_rvalid is 1.
  - Each port's data therefore stays stable until its next read completes, even while the other port uses the RAM.
- Stores:
  - The write commits at the grant edge; no rvalid is generated.
  - A load of the same address in the following cycle returns the new data.
- A granted request is complete at that edge. No outstanding transaction state exists beyond the rvalid pipeline bit.
  - A requester that lost holds req and address until granted.
  - A requester dropping req before grant is legal; the request is discarded.
- conflict_cnt increments on each edge with if_req & d_req and saturates at 0xFFFF.
- Reset (clear low, asynchronous):
  - if_rvalid = d_rvalid = 0; both hold registers = 0; conflict_cnt = 0; starvation counter = 0.
  - An in-flight read at reset is dropped; no rvalid follows deassertion.
  - Grants remain combinational during reset; the pipeline is cleared by the same signal.

Optional Feature:
- Macro ARB_FAIR_EN.
- When defined, a 3-bit starve counter is added.
  - It increments on each edge where if_req & d_req and data was granted.
  - It clears when fetch is granted or if_req is low.
  - When starve == STARVE_MAX and both request, fetch is granted instead of data (if_gnt = 1, d_gnt = 0); the counter clears at that edge.
- When undefined, strict data priority applies and the counter logic is absent.
- Port list is identical in both builds.

Decomposition:
- Shared package riscv_pkg holds ADDR_W/DATA_W defaults and the localparam grant encoding GNT_NONE=0, GNT_IF=1, GNT_D=2, used by debug/trace logic.
- One natural sub-module: arb_rport (rvalid flop, hold register, rdata mux), instantiated twice, once per port.
- Arbitration, steering and counters stay in mem_arbiter.

Test Plan:
- Preload RAM[0x10]=0xDEADBEEF; if_req=1, if_addr=0x10 with d_req=0.
  - Expect: if_gnt=1 same cycle; next cycle if_rvalid=1, if_rdata=0xDEADBEEF.
  - if_rdata holds 0xDEADBEEF after if_req drops.
- Both request in one cycle: d_req=1, d_we=0, d_addr=0x20 (RAM=0x55); if_addr=0x10.
  - Expect: d_gnt=1, if_gnt=0; then d_rvalid=1, d_rdata=0x55, if_rvalid=0; conflict_cnt=1.
  - Fetch is granted the following cycle.
- Store 0x12345678 to 0x30, then load 0x30 the next cycle.
  - Expect: ram_wren=1 for one cycle only, no d_rvalid for the store.
  - Load returns 0x12345678.
- Assert clear low one cycle after a granted fetch read.
  - Expect: if_rvalid=0, if_rdata=0, conflict_cnt=0 immediately; no rvalid after release.
- Hold both requests continuously for 10 cycles.
  - Strict build: fetch is never granted; conflict_cnt=10.
  - ARB_FAIR_EN build with STARVE_MAX=4: fetch is granted on cycle 5 and cycle 10.
- Hold both requests for 70000 cycles: conflict_cnt saturates at 0xFFFF, no wrap.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: default bus widths, grant encoding and a
// saturating counter helper used by the memory arbiter.
package riscv_pkg;

  localparam int RV_ADDR_W = 8;
  localparam int RV_DATA_W = 32;

  // Grant encoding, also meant for debug and trace logic.
  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_IF   = 2'd1;
  localparam logic [1:0] GNT_D    = 2'd2;

  localparam logic [15:0] CNT16_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == CNT16_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/arb_rport.sv
// One read-return port: rvalid pipeline bit, data hold register and the
// output mux that shows live RAM data on the valid cycle, held data otherwise.
module arb_rport
  import riscv_pkg::*;
#(
  parameter int DATA_W = RV_DATA_W
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              rd_gnt,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);

  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  always_comb begin
    rvalid_d = rd_gnt;
    hold_d   = rvalid_q ? ram_dout : hold_q;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      rvalid_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      hold_q   <= hold_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rvalid_q ? ram_dout : hold_q;

endmodule

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter in front of one single-port synchronous RAM.
// Data has strict priority unless ARB_FAIR_EN is defined, which forces fetch
// through after STARVE_MAX consecutive lost conflict cycles.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W     = RV_ADDR_W,
  parameter int DATA_W     = RV_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [15:0]       conflict_cnt
);

  // The starve counter is 3 bits wide, so the threshold must fit in it.
  if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_starve_max
    $error("mem_arbiter: STARVE_MAX must be in 1..7");
  end

  logic [1:0]  gnt_sel;
  logic        both_req;
  logic [15:0] conflict_q, conflict_d;

  assign both_req = if_req & d_req;

`ifdef ARB_FAIR_EN
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [2:0] starve_q, starve_d;

  always_comb begin
    gnt_sel = GNT_NONE;
    if (d_req) begin
      gnt_sel = GNT_D;
    end else if (if_req) begin
      gnt_sel = GNT_IF;
    end
    if (both_req && (starve_q == STARVE_LIM)) begin
      gnt_sel = GNT_IF;
    end
  end

  // Counts consecutive conflict cycles that fetch lost to data.
  always_comb begin
    starve_d = starve_q;
    if (!if_req || (gnt_sel == GNT_IF)) begin
      starve_d = 3'd0;
    end else if (both_req && (gnt_sel == GNT_D) && (starve_q != 3'd7)) begin
      starve_d = starve_q + 3'd1;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      starve_q <= 3'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  always_comb begin
    gnt_sel = GNT_NONE;
    if (d_req) begin
      gnt_sel = GNT_D;
    end else if (if_req) begin
      gnt_sel = GNT_IF;
    end
  end
`endif

  assign if_gnt   = (gnt_sel == GNT_IF);
  assign d_gnt    = (gnt_sel == GNT_D);
  assign ram_addr = d_gnt ? d_addr : if_addr;
  assign ram_din  = d_wdata;
  assign ram_wren = d_gnt & d_we;

  always_comb begin
    conflict_d = conflict_q;
    if (both_req) begin
      conflict_d = sat_inc16(conflict_q);
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      conflict_q <= 16'd0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict_cnt = conflict_q;

  arb_rport #(.DATA_W(DATA_W)) u_if_rport (
    .clock    (clock),
    .clear    (clear),
    .rd_gnt   (if_gnt),
    .ram_dout (ram_dout),
    .rvalid   (if_rvalid),
    .rdata    (if_rdata)
  );

  // Stores complete at the grant edge and never produce a read return.
  arb_rport #(.DATA_W(DATA_W)) u_d_rport (
    .clock    (clock),
    .clear    (clear),
    .rd_gnt   (d_gnt & ~d_we),
    .ram_dout (ram_dout),
    .rvalid   (d_rvalid),
    .rdata    (d_rdata)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, directed and random traffic, and a
// scoreboard comparing read returns and counters against a reference model.
module tb_mem_arbiter;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              clear;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_dout;
  logic [15:0]       conflict_cnt;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clock(clock), .clear(clear),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_wren(ram_wren),
    .ram_dout(ram_dout), .conflict_cnt(conflict_cnt)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- RAM environment ----------------
  logic [DATA_W-1:0] mem [256];
  always @(posedge clock) begin
    ram_dout <= mem[ram_addr];
    if (ram_wren) mem[ram_addr] = ram_din;
  end

  // ---------------- reference model state ----------------
  logic [DATA_W-1:0] ref_mem [256];
  logic [DATA_W-1:0] if_exp_q[$];
  logic [DATA_W-1:0] d_exp_q[$];
  logic [15:0]       exp_conf;
  int                lost_streak;
  logic [DATA_W-1:0] if_last, d_last;
  bit                mon_en;
  bit                if_pend, d_pend;
  logic              m_if, m_d;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // One request cycle: drive at negedge, check the combinational response,
  // then advance the reference model to the state after the next edge.
  task automatic drive_cycle(input logic ifr, input logic [ADDR_W-1:0] ifa,
                             input logic dr, input logic dwe,
                             input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dwd);
    logic [ADDR_W-1:0] exp_addr;
    @(negedge clock);
    if_req = ifr; if_addr = ifa; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    #1;
    m_d  = dr;
    m_if = ifr && !dr;
    if (FAIR && ifr && dr && lost_streak == STARVE_MAX) begin
      m_if = 1'b1;
      m_d  = 1'b0;
    end
    exp_addr = m_d ? da : ifa;
    check("if_gnt", {31'd0, if_gnt}, {31'd0, m_if});
    check("d_gnt", {31'd0, d_gnt}, {31'd0, m_d});
    check("ram_wren", {31'd0, ram_wren}, {31'd0, m_d && dwe});
    check("ram_addr", {24'd0, ram_addr}, {24'd0, exp_addr});
    check("ram_din", ram_din, dwd);
    if (m_if) if_exp_q.push_back(ref_mem[ifa]);
    if (m_d && !dwe) d_exp_q.push_back(ref_mem[da]);
    if (m_d && dwe) ref_mem[da] = dwd;
    if (ifr && dr && exp_conf != 16'hFFFF) exp_conf++;
    if (ifr && dr && m_d) lost_streak++;
    else if (!ifr || m_if) lost_streak = 0;
    if_pend = ifr && !m_if;
    d_pend  = dr && !m_d;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [DATA_W-1:0] mon_e;
  always @(posedge clock) begin
    #2;
    if (mon_en) begin
      check("if_rvalid", {31'd0, if_rvalid}, {31'd0, if_exp_q.size() != 0});
      if (if_exp_q.size() != 0) begin
        mon_e = if_exp_q.pop_front();
        check("if_rdata", if_rdata, mon_e);
        if_last = mon_e;
      end else begin
        check("if_hold", if_rdata, if_last);
      end
      check("d_rvalid", {31'd0, d_rvalid}, {31'd0, d_exp_q.size() != 0});
      if (d_exp_q.size() != 0) begin
        mon_e = d_exp_q.pop_front();
        check("d_rdata", d_rdata, mon_e);
        d_last = mon_e;
      end else begin
        check("d_hold", d_rdata, d_last);
      end
      check("conflict_cnt", {16'd0, conflict_cnt}, {16'd0, exp_conf});
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_if_rvalid"}, {31'd0, if_rvalid}, 32'd0);
    check({tag, "_d_rvalid"}, {31'd0, d_rvalid}, 32'd0);
    check({tag, "_if_rdata"}, if_rdata, 32'd0);
    check({tag, "_d_rdata"}, d_rdata, 32'd0);
    check({tag, "_conflict"}, {16'd0, conflict_cnt}, 32'd0);
  endtask

  task automatic model_reset();
    if_exp_q.delete();
    d_exp_q.delete();
    exp_conf = 16'd0;
    lost_streak = 0;
    if_last = '0;
    d_last = '0;
    if_pend = 1'b0;
    d_pend = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  logic              r_ifr, r_dr, r_dwe;
  logic [ADDR_W-1:0] r_ifa, r_da;

  initial begin
    mon_en = 1'b0;
    clear = 1'b0;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom();
      ref_mem[i] = mem[i];
    end
    mem[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
    mem[8'h20] = 32'h00000055; ref_mem[8'h20] = 32'h00000055;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_reset_state("por");
    @(negedge clock);
    clear = 1'b1;
    mon_en = 1'b1;

    // Single fetch read, then hold after the request drops.
    drive_cycle(1, 8'h10, 0, 0, 8'h00, 32'h0);
    drive_cycle(0, 8'h10, 0, 0, 8'h00, 32'h0);
    drive_cycle(0, 8'h00, 0, 0, 8'h00, 32'h0);

    // Conflict: data load wins, fetch follows next cycle.
    drive_cycle(1, 8'h10, 1, 0, 8'h20, 32'h0);
    check("conflict_d_first", {31'd0, d_gnt}, FAIR ? 32'd1 : 32'd1);
    drive_cycle(1, 8'h10, 0, 0, 8'h20, 32'h0);
    check("conflict_if_next", {31'd0, if_gnt}, 32'd1);
    drive_cycle(0, 8'h00, 0, 0, 8'h00, 32'h0);

    // Store then load of the same word.
    drive_cycle(0, 8'h00, 1, 1, 8'h30, 32'h12345678);
    drive_cycle(0, 8'h00, 1, 0, 8'h30, 32'h0);
    drive_cycle(0, 8'h00, 0, 0, 8'h00, 32'h0);
    drive_cycle(0, 8'h00, 0, 0, 8'h00, 32'h0);

    // Continuous conflict for 10 cycles.
    for (int k = 1; k <= 10; k++) begin
      drive_cycle(1, 8'h10, 1, 0, 8'h20, 32'h0);
      check("hold_both_if_gnt", {31'd0, if_gnt}, (FAIR && (k % 5 == 0)) ? 32'd1 : 32'd0);
    end
    drive_cycle(0, 8'h00, 0, 0, 8'h00, 32'h0);

    // Reset while a fetch read is in flight.
    drive_cycle(1, 8'h10, 0, 0, 8'h00, 32'h0);
    mon_en = 1'b0;
    #1 clear = 1'b0;
    #1;
    check_reset_state("async");
    if_req = 1'b0;
    @(posedge clock);
    #1;
    check_reset_state("held");
    @(negedge clock);
    clear = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    check("post_rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    check("post_rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    mon_en = 1'b1;

    // Random traffic; a loser usually keeps its request until granted.
    for (int n = 0; n < 3000; n++) begin
      if (!(if_pend && $urandom_range(0, 9) != 0)) begin
        r_ifr = ($urandom_range(0, 99) < 60);
        r_ifa = 8'($urandom_range(0, 15));
      end
      if (!(d_pend && $urandom_range(0, 9) != 0)) begin
        r_dr  = ($urandom_range(0, 99) < 50);
        r_dwe = ($urandom_range(0, 2) == 0);
        r_da  = 8'($urandom_range(0, 15));
      end
      drive_cycle(r_ifr, r_ifa, r_dr, r_dwe, r_da, $urandom());
    end

    // Saturation of the conflict counter.
    for (int n = 0; n < 70000; n++) begin
      drive_cycle(1, 8'h10, 1, 0, 8'h20, 32'h0);
    end
    drive_cycle(0, 8'h00, 0, 0, 8'h00, 32'h0);
    @(posedge clock);
    #3;
    check("conflict_saturated", {16'd0, conflict_cnt}, 32'h0000FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
